// File: rtl/six_step_commutator.sv
// Hall-sensed six-step commutator: filtered hall decode, PWM on the high leg,
// complementary/low-leg requests and per-leg dead-time FSMs driving registered gates.
module six_step_commutator #(
    parameter int DEADTIME_CYC = 8,
    parameter int HALL_FILT    = 4
) (
    input  logic        clk_ctrl,
    input  logic        rst_n,
    input  logic [11:0] pwm_ctr,
    input  logic        pwm_ctr_en,
    input  logic        run_en,
    input  logic [11:0] duty,
    input  logic        dir,
    input  logic        hall_1,
    input  logic        hall_2,
    input  logic        hall_3,
    output logic        inha,
    output logic        inla,
    output logic        inhb,
    output logic        inlb,
    output logic        inhc,
    output logic        inlc,
    output logic        drv_en,
    output logic [2:0]  sector,
    output logic        hall_fault
);

    typedef enum logic [1:0] {LEG_OFF = 2'd0, LEG_DT = 2'd1, LEG_HI = 2'd2, LEG_LO = 2'd3} leg_state_t;

    localparam logic [7:0] DT_LAST = 8'(DEADTIME_CYC - 1);
    localparam logic [4:0] FILT_N  = 5'(HALL_FILT);

    logic [2:0]  sync1_r, sync2_r, cand_r, sector_r;
    logic [3:0]  filt_cnt_r;
    logic [4:0]  filt_cnt_s;
    logic        hall_fault_r;
    logic [11:0] duty_q_r, duty_eff_s;
    logic        pwm_on_r;
    logic [1:0]  hi_leg_s, lo_leg_s;
    logic        kill_s;
    logic [1:0]  req_s [3];
    leg_state_t  state_r [3];
    leg_state_t  state_s [3];
    logic [7:0]  cnt_r [3];
    logic [7:0]  cnt_s [3];
    logic [1:0]  tgt_r [3];
    logic [1:0]  tgt_s [3];
    logic [2:0]  gate_hi_r, gate_lo_r, gate_hi_s, gate_lo_s;
    logic        drv_en_r;

    // Run length of identical synchronised samples that differ from the accepted code
    always_comb begin
        filt_cnt_s = 5'd0;
        if (sync2_r != sector_r) begin
            if (sync2_r == cand_r) begin
                filt_cnt_s = {1'b0, filt_cnt_r} + 5'd1;
            end else begin
                filt_cnt_s = 5'd1;
            end
        end else begin
            filt_cnt_s = 5'd0;
        end
    end

    // Hall synchroniser, glitch filter and accepted sector
    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r      <= 3'b000;
            sync2_r      <= 3'b000;
            cand_r       <= 3'b000;
            filt_cnt_r   <= 4'd0;
            sector_r     <= 3'b000;
            hall_fault_r <= 1'b1;
        end else begin
            sync1_r <= {hall_3, hall_2, hall_1};
            sync2_r <= sync1_r;
            cand_r  <= sync2_r;
            if (filt_cnt_s >= FILT_N) begin
                sector_r     <= sync2_r;
                hall_fault_r <= (sync2_r == 3'b000) || (sync2_r == 3'b111);
                filt_cnt_r   <= 4'd0;
            end else begin
                filt_cnt_r   <= filt_cnt_s[3:0];
            end
        end
    end

    // At the wrap the freshly loaded duty already governs count 0 of the new period
    always_comb begin
        if (pwm_ctr == 12'd0) begin
            duty_eff_s = duty;
        end else begin
            duty_eff_s = duty_q_r;
        end
    end

    // Period-latched duty and PWM compare, frozen while the counter is not qualified
    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            duty_q_r <= 12'd0;
            pwm_on_r <= 1'b0;
        end else if (pwm_ctr_en) begin
            pwm_on_r <= (pwm_ctr < duty_eff_s);
            if (pwm_ctr == 12'd0) begin
                duty_q_r <= duty;
            end
        end
    end

    // Forward commutation table; legs 0/1/2 = A/B/C, 3 = none
    always_comb begin
        hi_leg_s = 2'd3;
        lo_leg_s = 2'd3;
        case (sector_r)
            3'b101:  begin hi_leg_s = 2'd0; lo_leg_s = 2'd1; end
            3'b100:  begin hi_leg_s = 2'd0; lo_leg_s = 2'd2; end
            3'b110:  begin hi_leg_s = 2'd1; lo_leg_s = 2'd2; end
            3'b010:  begin hi_leg_s = 2'd1; lo_leg_s = 2'd0; end
            3'b011:  begin hi_leg_s = 2'd2; lo_leg_s = 2'd0; end
            3'b001:  begin hi_leg_s = 2'd2; lo_leg_s = 2'd1; end
            default: begin hi_leg_s = 2'd3; lo_leg_s = 2'd3; end
        endcase
    end

    // Per-leg switch request {high, low}; reverse rotation swaps the table legs
    always_comb begin
        kill_s = hall_fault_r | ~run_en;
        for (int i = 0; i < 3; i++) begin
            if (kill_s) begin
                req_s[i] = 2'b00;
            end else if (2'(i) == (dir ? hi_leg_s : lo_leg_s)) begin
                req_s[i] = {pwm_on_r, ~pwm_on_r};
            end else if (2'(i) == (dir ? lo_leg_s : hi_leg_s)) begin
                req_s[i] = 2'b01;
            end else begin
                req_s[i] = 2'b00;
            end
        end
    end

    // Dead-time FSM next state: turn-off immediate, every turn-on via a full DT interval
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_s[i] = state_r[i];
            cnt_s[i]   = cnt_r[i];
            tgt_s[i]   = tgt_r[i];
            if ((req_s[i] == 2'b00) || (req_s[i] == 2'b11)) begin
                state_s[i] = LEG_OFF;
                cnt_s[i]   = 8'd0;
                tgt_s[i]   = 2'b00;
            end else begin
                case (state_r[i])
                    LEG_HI, LEG_LO: begin
                        if (((state_r[i] == LEG_HI) && (req_s[i] == 2'b10)) ||
                            ((state_r[i] == LEG_LO) && (req_s[i] == 2'b01))) begin
                            state_s[i] = state_r[i];
                        end else begin
                            state_s[i] = LEG_DT;
                            cnt_s[i]   = 8'd0;
                            tgt_s[i]   = req_s[i];
                        end
                    end
                    LEG_DT: begin
                        if (req_s[i] != tgt_r[i]) begin
                            cnt_s[i] = 8'd0;
                            tgt_s[i] = req_s[i];
                        end else if (cnt_r[i] == DT_LAST) begin
                            state_s[i] = (tgt_r[i] == 2'b10) ? LEG_HI : LEG_LO;
                        end else begin
                            cnt_s[i] = cnt_r[i] + 8'd1;
                        end
                    end
                    default: begin
                        state_s[i] = LEG_DT;
                        cnt_s[i]   = 8'd0;
                        tgt_s[i]   = req_s[i];
                    end
                endcase
            end
        end
    end

    // Gate values decoded from the next state so the gate flops switch with the state
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            gate_hi_s[i] = (state_s[i] == LEG_HI);
            gate_lo_s[i] = (state_s[i] == LEG_LO);
        end
    end

    // Leg state, dead-time counters, gate and enable registers
    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                state_r[i] <= LEG_OFF;
                cnt_r[i]   <= 8'd0;
                tgt_r[i]   <= 2'b00;
            end
            gate_hi_r <= 3'b000;
            gate_lo_r <= 3'b000;
            drv_en_r  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
                tgt_r[i]   <= tgt_s[i];
            end
            gate_hi_r <= gate_hi_s;
            gate_lo_r <= gate_lo_s;
            drv_en_r  <= run_en;
        end
    end

    assign inha       = gate_hi_r[0];
    assign inla       = gate_lo_r[0];
    assign inhb       = gate_hi_r[1];
    assign inlb       = gate_lo_r[1];
    assign inhc       = gate_hi_r[2];
    assign inlc       = gate_lo_r[2];
    assign drv_en     = drv_en_r;
    assign sector     = sector_r;
    assign hall_fault = hall_fault_r;

endmodule

// File: doc/six_step_commutator.md
SIX_STEP_COMMUTATOR -- requirements
Module: six_step_commutator

Interface
REQ-001 Parameter DEADTIME_CYC, default 8, SHALL set the clk_ctrl cycles both switches of a leg are held off before either switch turns on (range 1-255).
REQ-002 Parameter HALL_FILT, default 4, SHALL set the consecutive identical synchronised hall samples required to accept a new hall code (range 1-15).
REQ-003 clk_ctrl  in  1  SHALL be the single control clock; the block has one clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous and active-low.
REQ-005 pwm_ctr  in  12  SHALL be the free-running PWM phase count from the timing hub.
REQ-006 pwm_ctr_en  in  1  SHALL qualify pwm_ctr; while low, PWM compare is frozen at its last result.
REQ-007 run_en  in  1  SHALL be the kill-stage run enable; low forces all gates off.
REQ-008 duty  in  12  SHALL be the requested high-side on-count per PWM period.
REQ-009 dir  in  1  SHALL select rotation: 1 forward, 0 reverse.
REQ-010 hall_1, hall_2, hall_3  in  1 each  SHALL be the raw asynchronous hall inputs.
REQ-011 inha, inla, inhb, inlb, inhc, inlc  out  1 each  SHALL be the registered gate-driver inputs, active-high.
REQ-012 drv_en  out  1  SHALL be the registered gate-driver enable.
REQ-013 sector  out  3  SHALL be the accepted hall code {hall_3,hall_2,hall_1}.
REQ-014 hall_fault  out  1  SHALL be high while the accepted code is 000 or 111.

Function
REQ-015 Each hall input SHALL pass a 2-FF synchroniser; the filter SHALL accept a new code after HALL_FILT consecutive identical synchronised samples differing from sector; latency raw edge to sector = 2 + HALL_FILT cycles.
REQ-016 duty_q SHALL load duty only on the cycle pwm_ctr_en=1 and pwm_ctr=0; duty changes mid-period SHALL not take effect until the next wrap.
REQ-017 pwm_on SHALL be registered as (pwm_ctr < duty_q) when pwm_ctr_en=1; duty_q=0 gives 0% on, duty_q=4095 gives on for all counts below 4095.
REQ-018 Forward table (code: high leg, low leg): 101 A/B, 100 A/C, 110 B/C, 010 B/A, 011 C/A, 001 C/B; reverse SHALL swap high and low legs; third leg floats.
REQ-019 Leg request SHALL be: high leg PWM -> high=pwm_on, low=~pwm_on (complementary); low leg -> low=1, high=0; floating leg -> both 0.
REQ-020 Per-leg dead-time FSM states OFF, DT, HI, LO: any request to turn a switch on from a state where it is off SHALL go via DT for DEADTIME_CYC cycles with both switches 0; turn-off SHALL be immediate (same cycle as request registered).
REQ-021 A request change during DT SHALL restart the DT count; a request for both off SHALL go to OFF from any state immediately.
REQ-022 hall_fault=1 or run_en=0 SHALL force all six gates to 0 on the next edge and all legs to OFF; recovery SHALL pass DT before any switch turns on.
REQ-023 drv_en SHALL be run_en registered one cycle; run_en falling and gates-off SHALL occur on the same edge.
REQ-024 inhX and inlX SHALL never both be 1 in any cycle, under any input sequence.
REQ-025 Simultaneous hall change and PWM edge SHALL resolve by requesting the new sector's leg states; dead-time rules apply per leg.

Reset
REQ-026 While rst_n=0: all gates 0, drv_en 0, sector 000, hall_fault 1, duty_q 0, synchronisers and filter count 0, legs OFF; deassertion mid-operation SHALL start from this state with no glitch on outputs.

Verification
REQ-027 dir=1, hall=101, duty=2048, run_en=1, DEADTIME_CYC=8: after settle, inha on for counts 0-2047, inhb=0, inlb=1, inla=~inha with 8-cycle gap both 0 each rising edge.
REQ-028 hall pulse 101->100 lasting HALL_FILT-1 cycles -> sector stays 101; lasting HALL_FILT cycles -> sector 100 after 2+HALL_FILT cycles, inlb off immediately, inlc on after 8 cycles.
REQ-029 hall=111 -> hall_fault=1, all gates 0 within one cycle of acceptance; return to 101 -> no switch on before 8 cycles.
REQ-030 run_en 1->0 mid-period -> all gates and drv_en 0 next edge; run_en 0->1 -> first on-edge no earlier than DEADTIME_CYC cycles later.
REQ-031 duty 1000->3000 at pwm_ctr=500 -> current period ends high-side at 1000, next period at 3000; duty 0 -> inhX never 1.
REQ-032 Random hall/duty/run_en/dir for 1e6 cycles plus random rst_n pulses -> assertion inhX&inlX never true; reset values as REQ-026.
